// File: rtl/stopwatch_lap.sv
// Centisecond stopwatch with run/stop/clear control, configurable prescaler and hour range,
// wrap-or-saturate overflow, and a small FIFO of captured lap times.
module stopwatch_lap #(
  parameter int CLK_PER_TICK = 100000,
  parameter int HR_MAX       = 23,
  parameter int HR_W         = 5,
  parameter int NUM_LAPS     = 4,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_startstop,
  input  logic                             i_clear,
  input  logic                             i_lap,
  input  logic                             i_lap_pop,
  output logic [6:0]                       o_cs,
  output logic [5:0]                       o_sec,
  output logic [5:0]                       o_min,
  output logic [HR_W-1:0]                  o_hr,
  output logic                             o_running,
  output logic                             o_wrap,
  output logic                             o_lap_valid,
  output logic [HR_W+18:0]                 o_lap_time,
  output logic [$clog2(NUM_LAPS+1)-1:0]    o_lap_count,
  output logic                             o_lap_ovf
);

  localparam int TW = HR_W + 19;
  localparam int CW = $clog2(NUM_LAPS + 1);
  localparam int PW = $clog2(CLK_PER_TICK);
  localparam int AW = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1;

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_TICK - 1);
  localparam logic [HR_W-1:0] HR_LAST    = HR_W'(HR_MAX);
  localparam logic [AW-1:0]   PTR_LAST   = AW'(NUM_LAPS - 1);
  localparam logic [CW-1:0]   CNT_FULL   = CW'(NUM_LAPS);

  logic [0:0]      state;
  logic [PW-1:0]   presc;
  logic [6:0]      cs_r;
  logic [5:0]      sec_r;
  logic [5:0]      min_r;
  logic [HR_W-1:0] hr_r;
  logic            wrap_r;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            ovf_r;
  logic [TW-1:0]   mem [NUM_LAPS];

  logic          running;
  logic          tick;
  logic          at_max;
  logic          push_req;
  logic          pop_ok;
  logic          fifo_full;
  logic          do_push;
  logic          lap_drop;
  logic [TW-1:0] now_time;
  logic [TW-1:0] next_time;

  // One-step carry chain; the caller never feeds it the maximum time.
  function automatic logic [TW-1:0] time_inc(input logic [TW-1:0] t);
    logic [HR_W-1:0] hr;
    logic [5:0]      mn;
    logic [5:0]      sc;
    logic [6:0]      c;
    {hr, mn, sc, c} = t;
    if (c != 7'd99) begin
      c = c + 7'd1;
    end else begin
      c = 7'd0;
      if (sc != 6'd59) begin
        sc = sc + 6'd1;
      end else begin
        sc = 6'd0;
        if (mn != 6'd59) begin
          mn = mn + 6'd1;
        end else begin
          mn = 6'd0;
          hr = hr + 1'b1;
        end
      end
    end
    return {hr, mn, sc, c};
  endfunction

  // Value taken by a tick at maximum time: hold in saturate mode, zero otherwise.
  function automatic logic [TW-1:0] sat_or_wrap(input logic [TW-1:0] t);
    return SATURATE ? t : '0;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign running   = (state == ST_RUNNING);
  assign tick      = running && (presc == PRESC_LAST);
  assign now_time  = {hr_r, min_r, sec_r, cs_r};
  assign at_max    = (hr_r == HR_LAST) && (min_r == 6'd59) && (sec_r == 6'd59) && (cs_r == 7'd99);
  assign next_time = at_max ? sat_or_wrap(now_time) : time_inc(now_time);

  // A pop frees the slot a same-cycle lap needs, so a full FIFO only drops without a pop.
  assign fifo_full = (count == CNT_FULL);
  assign push_req  = running && i_lap;
  assign pop_ok    = i_lap_pop && (count != '0);
  assign do_push   = push_req && (!fifo_full || pop_ok);
  assign lap_drop  = push_req && fifo_full && !pop_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_STOPPED;
      presc  <= '0;
      cs_r   <= '0;
      sec_r  <= '0;
      min_r  <= '0;
      hr_r   <= '0;
      wrap_r <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      wrap_r <= tick && at_max;

      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !pop_ok)      count <= count + 1'b1;
      else if (!do_push && pop_ok) count <= count - 1'b1;
      if (lap_drop) ovf_r <= 1'b1;

      if (running) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) {hr_r, min_r, sec_r, cs_r} <= next_time;
        if (i_startstop || (tick && at_max && SATURATE)) state <= ST_STOPPED;
      end else begin
        // Clear overrides any same-cycle pop; a same-cycle start then runs from zero.
        if (i_clear) begin
          presc  <= '0;
          cs_r   <= '0;
          sec_r  <= '0;
          min_r  <= '0;
          hr_r   <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
          ovf_r  <= 1'b0;
        end
        if (i_startstop) state <= ST_RUNNING;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= now_time;
  end

  assign o_cs        = cs_r;
  assign o_sec       = sec_r;
  assign o_min       = min_r;
  assign o_hr        = hr_r;
  assign o_running   = running;
  assign o_wrap      = wrap_r;
  assign o_lap_valid = (count != '0);
  assign o_lap_time  = o_lap_valid ? mem[rd_ptr] : '0;
  assign o_lap_count = count;
  assign o_lap_ovf   = ovf_r;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: vector table, directed corner sequences and random traffic
// checked against a total-centiseconds / queue reference model.
module tb_stopwatch_lap;

  localparam int CPT   = 4;
  localparam int HRM   = 23;
  localparam int HRW   = 5;
  localparam int NL    = 4;
  localparam int MAX_T = (HRM + 1) * 360000 - 1;

  logic clk = 1'b0;
  logic rst = 1'b0, ss = 1'b0, clr = 1'b0, lap = 1'b0, pop = 1'b0;

  logic [6:0]     cs;     logic [5:0] sec;   logic [5:0] mn;   logic [HRW-1:0] hr;
  logic           running, wrap, lap_valid, lap_ovf;
  logic [HRW+18:0] lap_time;
  logic [2:0]     lap_count;

  logic [6:0]     s_cs;   logic [5:0] s_sec; logic [5:0] s_mn; logic [HRW-1:0] s_hr;
  logic           s_running, s_wrap, s_lap_valid, s_lap_ovf;
  logic [HRW+18:0] s_lap_time;
  logic [2:0]     s_lap_count;

  stopwatch_lap #(.CLK_PER_TICK(CPT), .HR_MAX(HRM), .HR_W(HRW), .NUM_LAPS(NL), .SATURATE(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_startstop(ss), .i_clear(clr), .i_lap(lap), .i_lap_pop(pop),
    .o_cs(cs), .o_sec(sec), .o_min(mn), .o_hr(hr), .o_running(running), .o_wrap(wrap),
    .o_lap_valid(lap_valid), .o_lap_time(lap_time), .o_lap_count(lap_count), .o_lap_ovf(lap_ovf));

  stopwatch_lap #(.CLK_PER_TICK(CPT), .HR_MAX(HRM), .HR_W(HRW), .NUM_LAPS(NL), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_startstop(ss), .i_clear(clr), .i_lap(lap), .i_lap_pop(pop),
    .o_cs(s_cs), .o_sec(s_sec), .o_min(s_mn), .o_hr(s_hr), .o_running(s_running), .o_wrap(s_wrap),
    .o_lap_valid(s_lap_valid), .o_lap_time(s_lap_time), .o_lap_count(s_lap_count), .o_lap_ovf(s_lap_ovf));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model (wrap mode): time as total centiseconds, laps as a queue of totals.
  int m_total = 0;
  int m_presc = 0;
  bit m_run = 0, m_wrap = 0, m_ovf = 0;
  int q[$];

  function automatic logic [23:0] pack_t(input int t);
    int c = t % 100;
    int s = (t / 100) % 60;
    int m = (t / 6000) % 60;
    int h = t / 360000;
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit c, input bit l, input bit p);
    int pre;
    bit full;
    pre = m_total;
    if (r) begin
      m_total = 0; m_presc = 0; m_run = 0; m_wrap = 0; m_ovf = 0; q.delete();
      return;
    end
    m_wrap = 0;
    if (!m_run) begin
      if (c) begin
        m_total = 0; m_presc = 0; m_ovf = 0; q.delete();
      end else if (p && q.size() > 0) begin
        void'(q.pop_front());
      end
      if (s) m_run = 1;
    end else begin
      full = (q.size() == NL);
      if (p && q.size() > 0) void'(q.pop_front());
      if (l) begin
        if (full && !p) m_ovf = 1;
        else q.push_back(pre);
      end
      if (m_presc == CPT - 1) begin
        m_presc = 0;
        if (m_total == MAX_T) begin
          m_wrap = 1;
          m_total = 0;
        end else begin
          m_total++;
        end
      end else begin
        m_presc++;
      end
      if (s) m_run = 0;
    end
  endtask

  task automatic apply(input bit r, input bit s, input bit c, input bit l, input bit p);
    @(negedge clk);
    rst = r; ss = s; clr = c; lap = l; pop = p;
    @(posedge clk);
    model_step(r, s, c, l, p);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cs"},    cs,        m_total % 100);
    chk({tag, "_sec"},   sec,       (m_total / 100) % 60);
    chk({tag, "_min"},   mn,        (m_total / 6000) % 60);
    chk({tag, "_hr"},    hr,        m_total / 360000);
    chk({tag, "_run"},   running,   m_run);
    chk({tag, "_wrap"},  wrap,      m_wrap);
    chk({tag, "_valid"}, lap_valid, q.size() != 0);
    chk({tag, "_ltime"}, lap_time,  (q.size() != 0) ? pack_t(q[0]) : 0);
    chk({tag, "_count"}, lap_count, q.size());
    chk({tag, "_ovf"},   lap_ovf,   m_ovf);
  endtask

  typedef struct {
    bit r; bit s; bit c; bit l; bit p;
    int e_cs; int e_sec; bit e_run; int e_cnt; bit e_ovf; int e_lt; bit e_wrap;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int first_lap, cs_before, guard;

    //            r s c l p  cs sec run cnt ovf lt wrap
    tbl[0]  = '{1,0,0,0,0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0,1,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0,0,0,0,0, 1, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0,0,0,1,0, 1, 0, 1, 1, 0, 1, 0};
    tbl[7]  = '{0,0,1,0,0, 1, 0, 1, 1, 0, 1, 0};
    tbl[8]  = '{0,1,0,0,0, 1, 0, 0, 1, 0, 1, 0};
    tbl[9]  = '{0,0,0,1,0, 1, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{0,1,0,0,0, 1, 0, 1, 1, 0, 1, 0};
    tbl[11] = '{0,0,0,0,0, 2, 0, 1, 1, 0, 1, 0};
    tbl[12] = '{0,0,0,0,1, 2, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{0,0,0,0,1, 2, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{0,1,0,0,0, 2, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0,1,1,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[16] = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[17] = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[18] = '{0,0,0,0,0, 0, 0, 1, 0, 0, 0, 0};
    tbl[19] = '{0,0,0,0,0, 1, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].p);
      chk($sformatf("row%0d_cs", i),    cs,        tbl[i].e_cs);
      chk($sformatf("row%0d_sec", i),   sec,       tbl[i].e_sec);
      chk($sformatf("row%0d_run", i),   running,   tbl[i].e_run);
      chk($sformatf("row%0d_count", i), lap_count, tbl[i].e_cnt);
      chk($sformatf("row%0d_valid", i), lap_valid, tbl[i].e_cnt != 0);
      chk($sformatf("row%0d_ovf", i),   lap_ovf,   tbl[i].e_ovf);
      chk($sformatf("row%0d_ltime", i), lap_time,  tbl[i].e_lt);
      chk($sformatf("row%0d_wrap", i),  wrap,      tbl[i].e_wrap);
    end

    // 400 cycles of running after a start is exactly one second.
    apply(1, 0, 0, 0, 0);
    check_model("reset");
    apply(0, 1, 0, 0, 0);
    idle(400);
    chk("one_sec_sec", sec, 1);
    chk("one_sec_cs", cs, 0);
    check_model("one_sec");

    // Stop with the prescaler at 2; the partial tick survives a long stop.
    guard = 0;
    while (m_presc != 1 && guard < 8) begin idle(1); guard++; end
    chk("presc_align_bound", guard < 8, 1);
    apply(0, 1, 0, 0, 0);
    chk("stopped_at_presc2", running, 0);
    cs_before = cs;
    idle(50);
    chk("stop_hold_cs", cs, cs_before);
    apply(0, 1, 0, 0, 0);
    chk("restart_cs_e0", cs, cs_before);
    idle(1);
    chk("restart_cs_e1", cs, cs_before);
    idle(1);
    chk("restart_cs_e2", cs, cs_before + 1);
    check_model("restart");
    apply(0, 0, 1, 0, 0);
    chk("clear_running_ignored_sec", sec, 1);
    chk("clear_running_ignored_run", running, 1);
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0);
    chk("clear_cs", cs, 0);
    chk("clear_sec", sec, 0);
    chk("clear_min", mn, 0);
    chk("clear_hr", hr, 0);
    check_model("cleared");

    // Five laps into a four-deep FIFO.
    apply(0, 1, 0, 0, 0);
    first_lap = -1;
    for (int i = 0; i < 5; i++) begin
      idle(6);
      if (i == 0) first_lap = m_total;
      apply(0, 0, 0, 1, 0);
    end
    chk("five_laps_count", lap_count, 4);
    chk("five_laps_ovf", lap_ovf, 1);
    chk("five_laps_head", lap_time, pack_t(first_lap));
    check_model("five_laps");
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1);
    chk("drained_valid", lap_valid, 0);
    check_model("drained");
    apply(0, 0, 0, 0, 1);
    chk("empty_pop_count", lap_count, 0);
    chk("empty_pop_ltime", lap_time, 0);
    chk("empty_pop_ovf", lap_ovf, 1);

    // Lap on the tick edge at 0:00:00.99.
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0);
    apply(0, 1, 0, 0, 0);
    guard = 0;
    while (!(m_total == 99 && m_presc == CPT - 1) && guard < 1000) begin idle(1); guard++; end
    chk("lap_tick_align_bound", guard < 1000, 1);
    apply(0, 0, 0, 1, 0);
    chk("lap_tick_head", lap_time, 99);
    chk("lap_tick_live_cs", cs, 0);
    chk("lap_tick_live_sec", sec, 1);
    for (int i = 0; i < 3; i++) begin idle(5); apply(0, 0, 0, 1, 0); end
    chk("fill_count", lap_count, 4);
    chk("fill_ovf", lap_ovf, 0);
    apply(0, 0, 0, 1, 1);
    chk("lap_pop_full_count", lap_count, 4);
    chk("lap_pop_full_ovf", lap_ovf, 0);
    check_model("lap_pop_full");

    // Reset while running with two laps stored.
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    chk("pre_reset_count", lap_count, 2);
    chk("pre_reset_run", running, 1);
    apply(1, 0, 0, 0, 0);
    chk("rst_cs", cs, 0);   chk("rst_sec", sec, 0); chk("rst_min", mn, 0); chk("rst_hr", hr, 0);
    chk("rst_run", running, 0); chk("rst_wrap", wrap, 0); chk("rst_valid", lap_valid, 0);
    chk("rst_ltime", lap_time, 0); chk("rst_count", lap_count, 0); chk("rst_ovf", lap_ovf, 0);

    // Overflow at maximum time: both instances preloaded just before a tick edge.
    apply(0, 1, 0, 0, 0);
    guard = 0;
    while (m_presc != CPT - 1 && guard < 8) begin idle(1); guard++; end
    chk("max_align_bound", guard < 8, 1);
    force dut.cs_r = 7'd99;      force dut.sec_r = 6'd59;
    force dut.min_r = 6'd59;     force dut.hr_r = 5'd23;
    force dut_sat.cs_r = 7'd99;  force dut_sat.sec_r = 6'd59;
    force dut_sat.min_r = 6'd59; force dut_sat.hr_r = 5'd23;
    release dut.cs_r;     release dut.sec_r;     release dut.min_r;     release dut.hr_r;
    release dut_sat.cs_r; release dut_sat.sec_r; release dut_sat.min_r; release dut_sat.hr_r;
    m_total = MAX_T;
    idle(1);
    chk("wrap_pulse", wrap, 1);
    chk("wrap_time", {hr, mn, sec, cs}, 0);
    chk("wrap_running", running, 1);
    check_model("wrap");
    chk("sat_pulse", s_wrap, 1);
    chk("sat_time", {s_hr, s_mn, s_sec, s_cs}, pack_t(MAX_T));
    chk("sat_running", s_running, 0);
    idle(1);
    chk("wrap_pulse_end", wrap, 0);
    chk("sat_pulse_end", s_wrap, 0);
    chk("sat_hold", {s_hr, s_mn, s_sec, s_cs}, pack_t(MAX_T));
    apply(0, 1, 0, 0, 0);
    chk("sat_restart_run", s_running, 1);
    idle(3);
    chk("sat_restart_no_tick", s_wrap, 0);
    idle(1);
    chk("sat_resaturate_pulse", s_wrap, 1);
    chk("sat_resaturate_run", s_running, 0);
    chk("sat_resaturate_time", {s_hr, s_mn, s_sec, s_cs}, pack_t(MAX_T));
    check_model("after_sat");

    // Random pulse traffic against the model.
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 399) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
